// File: rtl/ctl_pkg.sv
// Shared constants for the multi-cycle controller: opcodes, functs, ALU codes,
// FSM state encoding and the decoded instruction class.
package ctl_pkg;

  localparam logic [5:0] OPC_R    = 6'd0;
  localparam logic [5:0] OPC_ADDI = 6'd8;
  localparam logic [5:0] OPC_LW   = 6'd35;
  localparam logic [5:0] OPC_SW   = 6'd43;
  localparam logic [5:0] OPC_BEQ  = 6'd4;
  localparam logic [5:0] OPC_J    = 6'd2;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef struct packed {
    logic r;
    logic addi;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic ill;
  } cls_t;

endpackage

// File: rtl/ctl_decode.sv
// Combinational decode of the latched opcode/funct into a one-hot instruction
// class and the ALU operation for yEX.
module ctl_decode
  import ctl_pkg::*;
(
  input  logic [5:0] i_opc,
  input  logic [5:0] i_funct,
  output cls_t       o_cls,
  output logic [2:0] o_alu_op
);

  always_comb begin
    o_cls = '0;
    case (i_opc)
      OPC_R:    o_cls.r    = 1'b1;
      OPC_ADDI: o_cls.addi = 1'b1;
      OPC_LW:   o_cls.lw   = 1'b1;
      OPC_SW:   o_cls.sw   = 1'b1;
      OPC_BEQ:  o_cls.beq  = 1'b1;
      OPC_J:    o_cls.j    = 1'b1;
      default:  o_cls.ill  = 1'b1;
    endcase
  end

  // Unknown R-type functs fall back to add.
  always_comb begin
    o_alu_op = ALU_ADD;
    if (o_cls.beq) begin
      o_alu_op = ALU_SUB;
    end else if (o_cls.r) begin
      case (i_funct)
        FN_ADD:  o_alu_op = ALU_ADD;
        FN_SUB:  o_alu_op = ALU_SUB;
        FN_AND:  o_alu_op = ALU_AND;
        FN_OR:   o_alu_op = ALU_OR;
        FN_SLT:  o_alu_op = ALU_SLT;
        default: o_alu_op = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/multi_cycle_ctl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB stepping, write
// strobes, reset-time entry-point load and retired-instruction counter.
//
//   state  | meaning
//   BOOT   | after reset: load entry point into PC (INT, pc_we)
//   FETCH  | load IR, latch opcode/funct
//   DECODE | classify; j/illegal retire here
//   EXEC   | ALU operation; beq retires here
//   MEM    | data memory access, wait for mem_ready; sw retires here
//   WB     | register write, PC update, retire
module multi_cycle_ctl
  import ctl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic             Mem2Reg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             beq,
  output logic             j,
  output logic [2:0]       op,
  output logic             INT,
  output logic             pc_we,
  output logic             ir_we,
  output logic             ill,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count
);

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_opc;
  logic [5:0]       r_funct;
  logic [CNT_W-1:0] r_count;
  cls_t             w_cls;
  logic [2:0]       w_alu_op;
  logic             w_unused;

  // zero is consumed by yPC directly; only the opcode/funct fields matter here.
  assign w_unused = ^{zero, ins[25:6]};

  ctl_decode u_decode (
    .i_opc    (r_opc),
    .i_funct  (r_funct),
    .o_cls    (w_cls),
    .o_alu_op (w_alu_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_opc   <= '0;
      r_funct <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH) begin
        r_opc   <= ins[31:26];
        r_funct <= ins[5:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (retire) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign instr_count = r_count;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_BOOT:   w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = (w_cls.j || w_cls.ill) ? S_FETCH : S_EXEC;
      S_EXEC: begin
        if (w_cls.beq)                  w_next = S_FETCH;
        else if (w_cls.lw || w_cls.sw)  w_next = S_MEM;
        else                            w_next = S_WB;
      end
      S_MEM: begin
        if (mem_ready) w_next = w_cls.sw ? S_FETCH : S_WB;
      end
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_BOOT;
    endcase
  end

  // Only sw's completion in MEM looks at an input; everything else is Moore.
  always_comb begin
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    Mem2Reg  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    beq      = 1'b0;
    j        = 1'b0;
    op       = 3'b000;
    INT      = 1'b0;
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    ill      = 1'b0;
    retire   = 1'b0;
    if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
      op     = w_alu_op;
      ALUSrc = !(w_cls.r || w_cls.beq);
      RegDst = w_cls.r;
    end
    case (r_state)
      S_BOOT: begin
        INT   = 1'b1;
        pc_we = 1'b1;
      end
      S_FETCH: ir_we = 1'b1;
      S_DECODE: begin
        if (w_cls.j || w_cls.ill) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
        j   = w_cls.j;
        ill = w_cls.ill;
      end
      S_EXEC: begin
        if (w_cls.beq) begin
          beq    = 1'b1;
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      S_MEM: begin
        MemRead  = w_cls.lw;
        MemWrite = w_cls.sw;
        if (w_cls.sw && mem_ready) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        Mem2Reg  = w_cls.lw;
        MemRead  = w_cls.lw;
        pc_we    = 1'b1;
        retire   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_ctl.sv
// Randomized self-checking bench for multi_cycle_ctl; expected per-cycle
// outputs come from an instruction-level timeline model.
module tb_multi_cycle_ctl;

  localparam int C_R = 0, C_ADDI = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_J = 5, C_ILL = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ins = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [15:0] vec, vec4;
  logic [31:0] cnt32;
  logic [3:0]  cnt4;
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_count = 0;

  always #5 clk = ~clk;

  multi_cycle_ctl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ins(ins), .zero(zero), .mem_ready(mem_ready),
    .RegDst(vec[15]), .RegWrite(vec[14]), .ALUSrc(vec[13]), .Mem2Reg(vec[12]),
    .MemRead(vec[11]), .MemWrite(vec[10]), .beq(vec[9]), .j(vec[8]), .op(vec[7:5]),
    .INT(vec[4]), .pc_we(vec[3]), .ir_we(vec[2]), .ill(vec[1]), .retire(vec[0]),
    .instr_count(cnt32)
  );

  multi_cycle_ctl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ins(ins), .zero(zero), .mem_ready(mem_ready),
    .RegDst(vec4[15]), .RegWrite(vec4[14]), .ALUSrc(vec4[13]), .Mem2Reg(vec4[12]),
    .MemRead(vec4[11]), .MemWrite(vec4[10]), .beq(vec4[9]), .j(vec4[8]), .op(vec4[7:5]),
    .INT(vec4[4]), .pc_we(vec4[3]), .ir_we(vec4[2]), .ill(vec4[1]), .retire(vec4[0]),
    .instr_count(cnt4)
  );

  function automatic logic [5:0] opc_of(int c);
    case (c)
      C_R:     return 6'd0;
      C_ADDI:  return 6'd8;
      C_LW:    return 6'd35;
      C_SW:    return 6'd43;
      C_BEQ:   return 6'd4;
      C_J:     return 6'd2;
      default: return 6'd63;
    endcase
  endfunction

  function automatic bit is_legal(logic [5:0] o);
    return o == 6'd0 || o == 6'd8 || o == 6'd35 || o == 6'd43 || o == 6'd4 || o == 6'd2;
  endfunction

  function automatic int instr_len(int c, int w);
    case (c)
      C_J, C_ILL:      return 2;
      C_BEQ:           return 3;
      C_R, C_ADDI:     return 4;
      C_SW:            return 4 + w;
      default:         return 5 + w;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(int c, logic [5:0] funct);
    if (c == C_BEQ) return 3'b110;
    if (c != C_R) return 3'b010;
    case (funct)
      6'd34:   return 3'b110;
      6'd36:   return 3'b000;
      6'd37:   return 3'b001;
      6'd42:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Expected outputs at cycle k of an instruction that takes len cycles.
  function automatic logic [15:0] exp_vec(int c, logic [5:0] funct, int k, int len);
    logic rd, rw, as, m2r, mr, mw, bq, jj, intr, pw, iw, il, rt;
    logic [2:0] o;
    {rd, rw, as, m2r, mr, mw, bq, jj, intr, pw, iw, il, rt} = '0;
    o = 3'b000;
    iw = (k == 0);
    if (k == len - 1) begin rt = 1'b1; pw = 1'b1; end
    jj = (c == C_J) && (k == 1);
    il = (c == C_ILL) && (k == 1);
    if (c != C_J && c != C_ILL && k >= 2) begin
      o  = alu_of(c, funct);
      as = !(c == C_R || c == C_BEQ);
      rd = (c == C_R);
    end
    bq  = (c == C_BEQ) && (k == 2);
    mr  = (c == C_LW) && (k >= 3);
    mw  = (c == C_SW) && (k >= 3);
    rw  = (c == C_R || c == C_ADDI || c == C_LW) && (k == len - 1);
    m2r = (c == C_LW) && (k == len - 1);
    return {rd, rw, as, m2r, mr, mw, bq, jj, o, intr, pw, iw, il, rt};
  endfunction

  // Runs one instruction from a visible FETCH; stops early at cycle stop_at.
  task automatic run_instr(int c, logic [5:0] opc, logic [5:0] funct, int w, logic z, int stop_at);
    int len;
    logic [31:0] r;
    logic [15:0] e;
    len = instr_len(c, w);
    for (int k = 0; k < len; k++) begin
      if (k == stop_at) return;
      r = $urandom();
      ins  = (k == 0) ? {opc, r[25:6], funct} : r;
      zero = z;
      if (k < 3) mem_ready = 1'($urandom_range(0, 1));
      else       mem_ready = (k >= 3 + w);
      #1;
      e = exp_vec(c, funct, k, len);
      n_checks++;
      if (vec !== e || vec4 !== e) begin
        n_errors++;
        $display("FAIL outputs cls=%0d k=%0d got=%h got4=%h exp=%h", c, k, vec, vec4, e);
      end
      if (e[0]) exp_count++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (cnt32 !== 32'(exp_count) || cnt4 !== 4'(exp_count)) begin
      n_errors++;
      $display("FAIL count got=%0d got4=%0d exp=%0d", cnt32, cnt4, exp_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (vec !== 16'h0018 || cnt32 !== 32'd0 || cnt4 !== 4'd0) begin
      n_errors++;
      $display("FAIL boot got=%h cnt=%0d exp=0018 cnt=0", vec, cnt32);
    end
    @(posedge clk); #1;
    n_checks++;
    if (vec !== 16'h0004 || cnt32 !== 32'd0) begin
      n_errors++;
      $display("FAIL first_fetch got=%h cnt=%0d exp=0004 cnt=0", vec, cnt32);
    end
    exp_count = 0;
  endtask

  task automatic test_rtype();
    run_instr(C_R, 6'd0, 6'd37, 0, 1'b0, -1);
    run_instr(C_R, 6'd0, 6'd42, 0, 1'b1, -1);
    run_instr(C_ADDI, 6'd8, 6'd37, 0, 1'b0, -1);
  endtask

  task automatic test_lw_wait();
    run_instr(C_LW, 6'd35, 6'd0, 3, 1'b0, -1);
    run_instr(C_LW, 6'd35, 6'd1, 0, 1'b0, -1);
    run_instr(C_SW, 6'd43, 6'd2, 2, 1'b0, -1);
    run_instr(C_SW, 6'd43, 6'd2, 0, 1'b0, -1);
  endtask

  task automatic test_beq();
    run_instr(C_BEQ, 6'd4, 6'd5, 0, 1'b1, -1);
    run_instr(C_BEQ, 6'd4, 6'd5, 0, 1'b0, -1);
  endtask

  task automatic test_j_ill();
    run_instr(C_J, 6'd2, 6'd9, 0, 1'b0, -1);
    run_instr(C_ILL, 6'd63, 6'd37, 0, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [5:0] o;
    int c;
    for (int n = 0; n < 40; n++) begin
      c = $urandom_range(0, 6);
      if (c == C_ILL) begin
        do o = 6'($urandom_range(0, 63)); while (is_legal(o));
      end else begin
        o = opc_of(c);
      end
      run_instr(c, o, 6'($urandom_range(30, 45)), $urandom_range(0, 4),
                1'($urandom_range(0, 1)), -1);
    end
  endtask

  task automatic test_reset_mid();
    run_instr(C_LW, 6'd35, 6'd0, 5, 1'b0, 4);
    mem_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (vec !== 16'h0018 || cnt32 !== 32'd0 || cnt4 !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_mid got=%h cnt=%0d exp=0018 cnt=0", vec, cnt32);
    end
    exp_count = 0;
    @(posedge clk); #1;
    n_checks++;
    if (vec !== 16'h0004) begin
      n_errors++;
      $display("FAIL reset_mid_fetch got=%h exp=0004", vec);
    end
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 16; n++) run_instr(C_J, 6'd2, 6'd0, 0, 1'b0, -1);
    n_checks++;
    if (cnt4 !== 4'd0 || cnt32 !== 32'd16) begin
      n_errors++;
      $display("FAIL wrap got4=%0d got32=%0d exp4=0 exp32=16", cnt4, cnt32);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_j_ill();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
